// File: rtl/switch_egress_xbar_if.sv
// Scheduler/FIFO/sink-facing signal bundle of the 3-port egress crossbar.
// The master side drives selects, FIFO read data and sink ready; the slave side is the crossbar.
interface switch_egress_xbar_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic [1:0]        sel1, sel2, sel3;
    logic [DATA_W-1:0] q1, q2, q3;
    logic              rdreq1, rdreq2, rdreq3;
    logic [DATA_W-1:0] out_data1, out_data2, out_data3;
    logic              out_valid1, out_valid2, out_valid3;
    logic              out_ready1, out_ready2, out_ready3;
    logic              out_full1, out_full2, out_full3;
    logic              conflict_err;
    logic [CNT_W-1:0]  cnt1, cnt2, cnt3;

    modport master (
        output sel1, sel2, sel3, q1, q2, q3, out_ready1, out_ready2, out_ready3,
        input  rdreq1, rdreq2, rdreq3, out_data1, out_data2, out_data3,
        input  out_valid1, out_valid2, out_valid3, out_full1, out_full2, out_full3,
        input  conflict_err, cnt1, cnt2, cnt3
    );

    modport slave (
        input  sel1, sel2, sel3, q1, q2, q3, out_ready1, out_ready2, out_ready3,
        output rdreq1, rdreq2, rdreq3, out_data1, out_data2, out_data3,
        output out_valid1, out_valid2, out_valid3, out_full1, out_full2, out_full3,
        output conflict_err, cnt1, cnt2, cnt3
    );
endinterface

// File: rtl/switch_egress_xbar.sv
// Egress crossbar: turns per-output select codes into FIFO read requests and buffers words per output.
// Optional forwarded-word counters are built only when XBAR_STATS_EN is defined.
module switch_egress_xbar #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    switch_egress_xbar_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [1:0]        sel [3];
    logic [DATA_W-1:0] q   [3];
    logic [2:0]        ready;

    assign sel[0] = bus.sel1;
    assign sel[1] = bus.sel2;
    assign sel[2] = bus.sel3;
    assign q[0]   = bus.q1;
    assign q[1]   = bus.q2;
    assign q[2]   = bus.q3;
    assign ready  = {bus.out_ready3, bus.out_ready2, bus.out_ready1};

    logic [DATA_W-1:0] mem [3][DEPTH];
    logic [PTR_W-1:0]  wp [3];
    logic [PTR_W-1:0]  rp [3];
    logic [OCC_W-1:0]  occ [3];
    logic [1:0]        pend_src [3];
    logic [2:0]        pend;
    logic [2:0]        full, valid, pop, acc_raw, acc, rdreq;
    logic              conflict, conflict_err;

    always_comb begin
        full     = '0;
        valid    = '0;
        pop      = '0;
        acc_raw  = '0;
        acc      = '0;
        rdreq    = '0;
        conflict = 1'b0;
        for (int k = 0; k < 3; k++) begin
            full[k]    = ({1'b0, occ[k]} + (OCC_W+1)'(pend[k])) >= (OCC_W+1)'(DEPTH);
            valid[k]   = (occ[k] != '0);
            pop[k]     = valid[k] && ready[k];
            acc_raw[k] = (sel[k] != 2'd0) && !full[k];
        end
        // Lower-numbered output keeps a contested source; higher ones drop their grant.
        for (int k = 0; k < 3; k++) begin
            acc[k] = acc_raw[k];
            for (int j = 0; j < k; j++) begin
                if (acc_raw[j] && acc_raw[k] && (sel[j] == sel[k])) begin
                    acc[k]   = 1'b0;
                    conflict = 1'b1;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (acc[k] && (sel[k] == 2'(i + 1))) rdreq[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend         <= '0;
            conflict_err <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                wp[k]       <= '0;
                rp[k]       <= '0;
                occ[k]      <= '0;
                pend_src[k] <= '0;
            end
        end else begin
            pend         <= acc;
            conflict_err <= conflict_err | conflict;
            for (int k = 0; k < 3; k++) begin
                pend_src[k] <= sel[k];
                if (pend[k]) begin
                    mem[k][wp[k]] <= q[pend_src[k] - 2'd1];
                    wp[k]         <= wp[k] + 1'b1;
                end
                if (pop[k]) rp[k] <= rp[k] + 1'b1;
                occ[k] <= occ[k] + OCC_W'(pend[k]) - OCC_W'(pop[k]);
            end
        end
    end

    assign bus.rdreq1       = rdreq[0];
    assign bus.rdreq2       = rdreq[1];
    assign bus.rdreq3       = rdreq[2];
    assign bus.out_valid1   = valid[0];
    assign bus.out_valid2   = valid[1];
    assign bus.out_valid3   = valid[2];
    assign bus.out_full1    = full[0];
    assign bus.out_full2    = full[1];
    assign bus.out_full3    = full[2];
    assign bus.conflict_err = conflict_err;
    // Data is forced to zero while a buffer is empty so reset and idle read back as 0.
    assign bus.out_data1    = valid[0] ? mem[0][rp[0]] : '0;
    assign bus.out_data2    = valid[1] ? mem[1][rp[1]] : '0;
    assign bus.out_data3    = valid[2] ? mem[2][rp[2]] : '0;

`ifdef XBAR_STATS_EN
    logic [CNT_W-1:0] cnt [3];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (pop[k] && (cnt[k] != '1)) cnt[k] <= cnt[k] + 1'b1;
            end
        end
    end

    assign bus.cnt1 = cnt[0];
    assign bus.cnt2 = cnt[1];
    assign bus.cnt3 = cnt[2];
`else
    assign bus.cnt1 = '0;
    assign bus.cnt2 = '0;
    assign bus.cnt3 = '0;
`endif
endmodule

// File: tb/tb_switch_egress_xbar.sv
// Directed bench for switch_egress_xbar: vector table plus streaming, sticky-error, reset and counter sequences.
module tb_switch_egress_xbar;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    switch_egress_xbar_if #(.DATA_W(8), .CNT_W(2))  bus ();
    switch_egress_xbar_if #(.DATA_W(8), .CNT_W(16)) bus4 ();

    switch_egress_xbar #(.DATA_W(8), .DEPTH(2), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Deeper instance so a steady one-word-per-cycle stream never looks full.
    switch_egress_xbar #(.DATA_W(8), .DEPTH(4), .CNT_W(16)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] s1, s2, s3;
        logic [7:0] q1, q2, q3;
        logic [2:0] rdy;
        logic [2:0] rdreq, valid, full;
        logic [7:0] d1, d2, d3;
        logic       cerr;
    } vec_t;

    vec_t vt [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] s3,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [2:0] rdy);
        bus.sel1 = s1; bus.sel2 = s2; bus.sel3 = s3;
        bus.q1 = a;    bus.q2 = b;    bus.q3 = c;
        bus.out_ready1 = rdy[0]; bus.out_ready2 = rdy[1]; bus.out_ready3 = rdy[2];
    endtask

    function automatic logic [2:0] rdreq_v();
        return {bus.rdreq3, bus.rdreq2, bus.rdreq1};
    endfunction
    function automatic logic [2:0] valid_v();
        return {bus.out_valid3, bus.out_valid2, bus.out_valid1};
    endfunction
    function automatic logic [2:0] full_v();
        return {bus.out_full3, bus.out_full2, bus.out_full1};
    endfunction

    initial begin
        logic [31:0] exp_cnt;
        n_vec = 0;
        n_bad = 0;

        // single grant: output 1 from input 2
        vt[0]  = '{2'd2, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 3'b001, 3'b010, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0};
        vt[1]  = '{2'd0, 2'd0, 2'd0, 8'h00, 8'hA5, 8'h00, 3'b001, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0};
        vt[2]  = '{2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 3'b001, 3'b000, 3'b001, 3'b000, 8'hA5, 8'h00, 8'h00, 1'b0};
        vt[3]  = '{2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 3'b001, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0};
        // back-pressure on output 2: third grant rejected while full
        vt[4]  = '{2'd0, 2'd1, 2'd0, 8'h00, 8'h00, 8'h00, 3'b000, 3'b001, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0};
        vt[5]  = '{2'd0, 2'd1, 2'd0, 8'h11, 8'h00, 8'h00, 3'b000, 3'b001, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0};
        vt[6]  = '{2'd0, 2'd1, 2'd0, 8'h22, 8'h00, 8'h00, 3'b000, 3'b000, 3'b010, 3'b010, 8'h00, 8'h11, 8'h00, 1'b0};
        vt[7]  = '{2'd0, 2'd0, 2'd0, 8'h33, 8'h00, 8'h00, 3'b000, 3'b000, 3'b010, 3'b010, 8'h00, 8'h11, 8'h00, 1'b0};
        vt[8]  = '{2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 3'b010, 3'b000, 3'b010, 3'b010, 8'h00, 8'h11, 8'h00, 1'b0};
        vt[9]  = '{2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 3'b010, 3'b000, 3'b010, 3'b000, 8'h00, 8'h22, 8'h00, 1'b0};
        vt[10] = '{2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 3'b010, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0};
        // three outputs on three distinct inputs in one cycle
        vt[11] = '{2'd3, 2'd1, 2'd2, 8'h00, 8'h00, 8'h00, 3'b111, 3'b111, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0};
        vt[12] = '{2'd0, 2'd0, 2'd0, 8'h10, 8'h20, 8'h30, 3'b111, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0};
        vt[13] = '{2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 3'b111, 3'b000, 3'b111, 3'b000, 8'h30, 8'h10, 8'h20, 1'b0};
        vt[14] = '{2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 3'b111, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0};
        // conflict: outputs 1 and 3 both want input 3, output 1 wins
        vt[15] = '{2'd3, 2'd0, 2'd3, 8'h00, 8'h00, 8'h00, 3'b101, 3'b100, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0};
        vt[16] = '{2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h5A, 3'b101, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1};
        vt[17] = '{2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 3'b101, 3'b000, 3'b001, 3'b000, 8'h5A, 8'h00, 8'h00, 1'b1};
        vt[18] = '{2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 3'b101, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1};

        rst_n = 1'b0;
        drive(2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 3'b000);
        bus4.sel1 = 2'd0; bus4.sel2 = 2'd0; bus4.sel3 = 2'd0;
        bus4.q1 = 8'h00;  bus4.q2 = 8'h00;  bus4.q3 = 8'h00;
        bus4.out_ready1 = 1'b0; bus4.out_ready2 = 1'b0; bus4.out_ready3 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset rdreq", 32'(rdreq_v()), 32'h0);
        check("reset valid", 32'(valid_v()), 32'h0);
        check("reset full", 32'(full_v()), 32'h0);
        check("reset data1", 32'(bus.out_data1), 32'h0);
        check("reset conflict_err", 32'(bus.conflict_err), 32'h0);
        check("reset cnt1", 32'(bus.cnt1), 32'h0);

        for (int i = 0; i < 19; i++) begin
            @(posedge clk);
            #1 drive(vt[i].s1, vt[i].s2, vt[i].s3, vt[i].q1, vt[i].q2, vt[i].q3, vt[i].rdy);
            @(negedge clk);
            check($sformatf("vec%0d rdreq", i), 32'(rdreq_v()), 32'(vt[i].rdreq));
            check($sformatf("vec%0d valid", i), 32'(valid_v()), 32'(vt[i].valid));
            check($sformatf("vec%0d full", i), 32'(full_v()), 32'(vt[i].full));
            check($sformatf("vec%0d conflict_err", i), 32'(bus.conflict_err), 32'(vt[i].cerr));
            if (vt[i].valid[0]) check($sformatf("vec%0d data1", i), 32'(bus.out_data1), 32'(vt[i].d1));
            if (vt[i].valid[1]) check($sformatf("vec%0d data2", i), 32'(bus.out_data2), 32'(vt[i].d2));
            if (vt[i].valid[2]) check($sformatf("vec%0d data3", i), 32'(bus.out_data3), 32'(vt[i].d3));
        end

        // conflict_err stays set through idle cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sticky conflict_err", 32'(bus.conflict_err), 32'h1);

        // streaming on the deep instance: output 3 from input 1, eight words
        for (int c = 0; c <= 10; c++) begin
            @(posedge clk);
            #1;
            bus4.sel3       = (c <= 7) ? 2'd1 : 2'd0;
            bus4.q1         = (c >= 1 && c <= 8) ? 8'(c) : 8'h00;
            bus4.out_ready3 = 1'b1;
            @(negedge clk);
            check($sformatf("stream c%0d rdreq1", c), 32'(bus4.rdreq1), (c <= 7) ? 32'h1 : 32'h0);
            check($sformatf("stream c%0d valid3", c), 32'(bus4.out_valid3), (c >= 2 && c <= 9) ? 32'h1 : 32'h0);
            check($sformatf("stream c%0d full3", c), 32'(bus4.out_full3), 32'h0);
            if (c >= 2 && c <= 9) check($sformatf("stream c%0d data3", c), 32'(bus4.out_data3), 32'(c - 1));
        end
        #1 bus4.sel3 = 2'd0;

        // reset right after a grant: the returning word must be dropped
        @(posedge clk);
        #1 drive(2'd1, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 3'b001);
        @(negedge clk);
        check("rstmid grant rdreq", 32'(rdreq_v()), 32'h1);
        @(posedge clk);
        #1 drive(2'd0, 2'd0, 2'd0, 8'h77, 8'h00, 8'h00, 3'b001);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(2'd0, 2'd0, 2'd0, 8'h88, 8'h00, 8'h00, 3'b001);
        @(negedge clk);
        check("rstmid valid", 32'(valid_v()), 32'h0);
        check("rstmid full", 32'(full_v()), 32'h0);
        check("rstmid rdreq", 32'(rdreq_v()), 32'h0);
        check("rstmid data1", 32'(bus.out_data1), 32'h0);
        check("rstmid conflict_err", 32'(bus.conflict_err), 32'h0);
        check("rstmid cnt1", 32'(bus.cnt1), 32'h0);
        @(posedge clk);
        #1 drive(2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 3'b001);
        @(negedge clk);
        check("rstmid post valid", 32'(valid_v()), 32'h0);

        // five single transfers on output 1; counter saturates at 3 when built
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 drive(2'd1, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 3'b001);
            @(posedge clk);
            #1 drive(2'd0, 2'd0, 2'd0, 8'(8'hC0 + i), 8'h00, 8'h00, 3'b001);
            @(posedge clk);
            #1 drive(2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 3'b001);
            @(negedge clk);
            check($sformatf("stats xfer%0d valid1", i), 32'(bus.out_valid1), 32'h1);
            check($sformatf("stats xfer%0d data1", i), 32'(bus.out_data1), 32'(8'hC0 + i));
            @(posedge clk);
            #1;
            @(negedge clk);
`ifdef XBAR_STATS_EN
            exp_cnt = (i + 1 > 3) ? 32'd3 : 32'(i + 1);
`else
            exp_cnt = 32'd0;
`endif
            check($sformatf("stats xfer%0d cnt1", i), 32'(bus.cnt1), exp_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/switch_egress_xbar.md
Name: switch_egress_xbar

Overview:
- Egress stage of the 3-port switch, directly downstream of the scheduler.
- Takes the per-output select codes (sel1..sel3) and generates the input-FIFO read requests.
- Captures the selected FIFO words into a small buffer per output and presents each output with a valid/ready handshake.
- Returns per-output full flags so the scheduler can hold off grants.

Parameters:
- DATA_W, 8, width of a switched word; bits [1:0] are the destination field.
- DEPTH, 2, entries per egress buffer; power of 2, at least 2.
- CNT_W, 16, width of per-output forwarded-word counters.

Ports:
- clk  in  1  system clock, all logic on its rising edge
- rst_n  in  1  synchronous reset, active-low
- sel1, sel2, sel3  in  2 each  select for output k: 0=idle, 1/2/3=source input FIFO 1/2/3
- q1, q2, q3  in  DATA_W each  input FIFO read data, valid the cycle after the matching rdreq
- rdreq1, rdreq2, rdreq3  out  1 each  read request to input FIFO 1/2/3
- out_data1, out_data2, out_data3  out  DATA_W each  head of egress buffer k
- out_valid1, out_valid2, out_valid3  out  1 each  egress buffer k non-empty
- out_ready1, out_ready2, out_ready3  in  1 each  sink accepts word k
- out_full1, out_full2, out_full3  out  1 each  output k cannot accept a new grant
- conflict_err  out  1  sticky: two outputs selected the same input in one cycle
- cnt1, cnt2, cnt3  out  CNT_W each  forwarded-word counters (see Optional Feature)

Behaviour:
- Reset, when rst_n=0 at a clk edge:
  - all buffers are emptied and all pending captures are discarded;
  - rdreq=0, out_valid=0, out_data=0, out_full=0, conflict_err=0, cnt=0.
  - A FIFO word returning in the cycle after reset is ignored.
- Per-output state:
  - occupancy count occ_k, 0..DEPTH;
  - pend_k flag, set when a grant was issued last cycle;
  - pend_src_k, 2 bits, the source input of that grant.
- out_full_k is registered-state combinational: out_full_k = (occ_k + pend_k >= DEPTH). It does not account for a same-cycle pop.
- Grant acceptance for output k in cycle N requires sel_k != 0 and out_full_k = 0.
  - Rejected sel values are ignored silently.
- Conflict: two or more outputs accept the same source in one cycle.
  - The lowest-numbered output wins; the others are ignored.
  - conflict_err is set and stays set until reset.
- rdreq_i is combinational, asserted in cycle N iff some accepted grant targets input i. At most one rdreq per input per cycle.
- Capture, cycle N+1:
  - if pend_k=1, q[pend_src_k] is written into buffer k at the tail;
  - pend_k is then cleared unless a new grant is accepted in N+1.
  - Back-to-back grants are allowed: one word per output per cycle.
- Latency: sel accepted at N, rdreq at N, word written at the end of N+1, out_valid_k=1 at N+2 at the earliest.
- Egress handshake:
  - the word transfers on a cycle where out_valid_k and out_ready_k are both 1, and the head pointer advances;
  - out_data_k is the buffer head and is stable while out_valid_k=1 and out_ready_k=0;
  - a simultaneous push and pop leaves occ_k unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Overflow cannot occur by construction; underflow is prevented because a pop requires out_valid_k.
- Word content is forwarded unmodified.

Optional Feature:
- Macro: XBAR_STATS_EN.
- Defined:
  - cnt_k increments by 1 on each egress transfer of output k;
  - it saturates at 2^CNT_W-1 and does not wrap;
  - it resets to 0.
- Not defined: the cnt ports remain, tied to 0, and no counter logic is built.

Test Plan:
- Single grant: after reset, sel1=2 for one cycle, q2=0xA5 at N+1, out_ready1=1 -> rdreq2=1 at N only; out_data1=0xA5 with out_valid1=1 at N+2 for exactly one cycle.
- Back-pressure: out_ready2=0, sel2=1 on three consecutive cycles, DEPTH=2 -> rdreq1 pulses twice; out_full2=1 from the third cycle; third grant ignored; releasing out_ready2 drains both words in order.
- Conflict: sel1=3 and sel3=3 in the same cycle -> rdreq3=1 once; word lands in output 1 only; conflict_err=1 and held until rst_n=0.
- Streaming: sel3=1 every cycle for 8 cycles, out_ready3=1, q1 carrying 0x01..0x08 -> out_valid3 continuous for 8 cycles starting at N+2, data 0x01..0x08 in order, out_full3 never asserted.
- Reset mid-operation: grant at N, rst_n=0 at N+1 -> nothing captured; all outputs 0 after the reset edge; no out_valid until a new grant.
- Stats, with XBAR_STATS_EN defined and CNT_W=2: 5 transfers on output 1 -> cnt1 reads 1, 2, 3, 3, 3; with the macro undefined, cnt1 stays 0.
